// File: rtl/pes_clk_div_ctrl.sv
// pes_clk_div_ctrl: run-time integer clock divider with boundary-aligned divisor changes and stops.
// Optional macro DIV_ERR_EN: divisors below 2 are rejected and flagged on cfg_err instead of clamped.
module pes_clk_div_ctrl #(
    parameter int unsigned      WIDTH       = 28,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = 28'd2
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clock_out,
    output logic             tick,
    output logic             busy,
    output logic [WIDTH-1:0] active_div
`ifdef DIV_ERR_EN
    ,
    output logic             cfg_err
`endif
);

    localparam logic [1:0] ST_STOP     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_STOPPING = 2'd2;

    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_DIV = {{(WIDTH-2){1'b0}}, 2'b10};

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_nxt_s;
    logic [WIDTH-1:0] active_div_r;
    logic [WIDTH-1:0] active_div_nxt_s;
    logic [WIDTH-1:0] pend_div_r;
    logic [WIDTH-1:0] pend_div_nxt_s;
    logic             pend_r;
    logic             pend_nxt_s;
    logic             clk_out_r;
    logic             clk_out_nxt_s;
    logic             tick_r;
    logic             busy_r;
    logic             cfg_ready_r;
    logic             running_s;
    logic             term_s;
    logic             xfer_s;
    logic             xfer_ok_s;
    logic [WIDTH-1:0] cfg_val_s;
    logic [WIDTH-1:0] last_cnt_s;
    logic [WIDTH-1:0] half_div_s;

`ifdef DIV_ERR_EN
    logic             div_small_s;
    logic             cfg_err_r;
`else
    // Values below the minimum legal divisor are forced up to it.
    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
        if (d < MIN_DIV) begin
            clamp_div = MIN_DIV;
        end else begin
            clamp_div = d;
        end
    endfunction
`endif

    // Period bookkeeping and handshake qualification.
    always_comb begin
        running_s  = (state_r != ST_STOP);
        last_cnt_s = active_div_r - ONE_W;
        half_div_s = active_div_r >> 1;
        term_s     = running_s && (cnt_r >= last_cnt_s);
        xfer_s     = cfg_valid && cfg_ready_r;
`ifdef DIV_ERR_EN
        div_small_s = (cfg_div < MIN_DIV);
        xfer_ok_s   = xfer_s && !div_small_s;
        cfg_val_s   = cfg_div;
`else
        xfer_ok_s   = xfer_s;
        cfg_val_s   = clamp_div(cfg_div);
`endif
    end

    // Run/stop sequencing; stops only complete on a terminal cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_STOP: begin
                if (enable) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_RUN, ST_STOPPING: begin
                if (enable) begin
                    state_nxt_s = ST_RUN;
                end else if (term_s) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_STOPPING;
                end
            end
            default: begin
                state_nxt_s = ST_STOP;
            end
        endcase
    end

    // Divide counter and the registered clock level derived from it.
    always_comb begin
        cnt_nxt_s = ZERO_W;
        if (!running_s || term_s) begin
            cnt_nxt_s = ZERO_W;
        end else begin
            cnt_nxt_s = cnt_r + ONE_W;
        end
        clk_out_nxt_s = running_s && (cnt_r < half_div_s);
    end

    // Divisor update: immediate when stopped or on a boundary, otherwise parked until the next boundary.
    always_comb begin
        active_div_nxt_s = active_div_r;
        pend_div_nxt_s   = pend_div_r;
        pend_nxt_s       = pend_r;
        if (!running_s || term_s) begin
            if (xfer_ok_s) begin
                active_div_nxt_s = cfg_val_s;
            end else if (pend_r) begin
                active_div_nxt_s = pend_div_r;
                pend_nxt_s       = 1'b0;
            end else begin
                active_div_nxt_s = active_div_r;
            end
        end else begin
            if (xfer_ok_s) begin
                pend_div_nxt_s = cfg_val_s;
                pend_nxt_s     = 1'b1;
            end else begin
                pend_nxt_s     = pend_r;
            end
        end
    end

    // State and output registers; reset discards any parked divisor.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_r      <= ST_STOP;
            cnt_r        <= ZERO_W;
            active_div_r <= DEFAULT_DIV;
            pend_div_r   <= ZERO_W;
            pend_r       <= 1'b0;
            clk_out_r    <= 1'b0;
            tick_r       <= 1'b0;
            busy_r       <= 1'b0;
            cfg_ready_r  <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            active_div_r <= active_div_nxt_s;
            pend_div_r   <= pend_div_nxt_s;
            pend_r       <= pend_nxt_s;
            clk_out_r    <= clk_out_nxt_s;
            tick_r       <= term_s;
            busy_r       <= (state_nxt_s != ST_STOP);
            cfg_ready_r  <= !pend_nxt_s;
        end
    end

`ifdef DIV_ERR_EN
    // One-cycle flag for a rejected divisor.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= xfer_s && div_small_s;
        end
    end

    assign cfg_err = cfg_err_r;
`endif

    assign cfg_ready  = cfg_ready_r;
    assign clock_out  = clk_out_r;
    assign tick       = tick_r;
    assign busy       = busy_r;
    assign active_div = active_div_r;

endmodule

// File: tb/tb_pes_clk_div_ctrl.sv
// Directed bench for pes_clk_div_ctrl; build with +define+DIV_ERR_EN to exercise cfg_err.
module tb_pes_clk_div_ctrl;

    localparam int WIDTH = 28;

    logic             clock_in  = 1'b0;
    logic             reset     = 1'b1;
    logic             enable    = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [WIDTH-1:0] cfg_div   = 28'd0;
    logic             cfg_ready;
    logic             clock_out;
    logic             tick;
    logic             busy;
    logic [WIDTH-1:0] active_div;
`ifdef DIV_ERR_EN
    logic             cfg_err;
`endif

    int cmp_cnt = 0;
    int mis_cnt = 0;

    pes_clk_div_ctrl #(.WIDTH(WIDTH), .DEFAULT_DIV(28'd2)) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .clock_out  (clock_out),
        .tick       (tick),
        .busy       (busy),
        .active_div (active_div)
`ifdef DIV_ERR_EN
        ,
        .cfg_err    (cfg_err)
`endif
    );

    // Free-running system clock.
    always #5 clock_in = ~clock_in;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        if (obs !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One active edge, then settle before looking at outputs or changing inputs.
    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        step();
        step();
        reset     = 1'b0;
    endtask

    task automatic program_div(input logic [WIDTH-1:0] v);
        cfg_div   = v;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        cfg_div   = 28'd1;
    endtask

    // Patterns are written oldest edge first (leftmost bit).
    task automatic run_expect(input string tag, input int n, input logic [15:0] clk_pat,
                              input logic [15:0] tick_pat, input logic [15:0] busy_pat);
        for (int i = 0; i < n; i++) begin
            step();
            check_val($sformatf("%s clk[%0d]", tag, i), 32'(clock_out), 32'(clk_pat[n-1-i]));
            check_val($sformatf("%s tick[%0d]", tag, i), 32'(tick), 32'(tick_pat[n-1-i]));
            check_val($sformatf("%s busy[%0d]", tag, i), 32'(busy), 32'(busy_pat[n-1-i]));
        end
    endtask

    initial begin
        // Test 1: reset values, then default divide-by-2.
        reset = 1'b1;
        step();
        step();
        check_val("rst clk", 32'(clock_out), 32'd0);
        check_val("rst tick", 32'(tick), 32'd0);
        check_val("rst busy", 32'(busy), 32'd0);
        check_val("rst div", 32'(active_div), 32'd2);
        check_val("rst ready", 32'(cfg_ready), 32'd1);
`ifdef DIV_ERR_EN
        check_val("rst err", 32'(cfg_err), 32'd0);
`endif
        reset  = 1'b0;
        enable = 1'b1;
        step();
        check_val("t1 e0 busy", 32'(busy), 32'd1);
        check_val("t1 e0 clk", 32'(clock_out), 32'd0);
        run_expect("t1", 6, 16'b101010, 16'b010101, 16'b111111);

        // Test 2: divisor change parked mid-period, applied at the boundary.
        do_reset();
        program_div(28'd4);
        check_val("t2 div4", 32'(active_div), 32'd4);
        enable = 1'b1;
        step();
        step();
        check_val("t2 e1 clk", 32'(clock_out), 32'd1);
        cfg_div   = 28'd6;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        cfg_div   = 28'd9;
        check_val("t2 e2 ready", 32'(cfg_ready), 32'd0);
        check_val("t2 e2 div", 32'(active_div), 32'd4);
        check_val("t2 e2 clk", 32'(clock_out), 32'd1);
        step();
        check_val("t2 e3 ready", 32'(cfg_ready), 32'd0);
        check_val("t2 e3 clk", 32'(clock_out), 32'd0);
        check_val("t2 e3 div", 32'(active_div), 32'd4);
        step();
        check_val("t2 e4 tick", 32'(tick), 32'd1);
        check_val("t2 e4 clk", 32'(clock_out), 32'd0);
        check_val("t2 e4 div", 32'(active_div), 32'd6);
        check_val("t2 e4 ready", 32'(cfg_ready), 32'd1);
        run_expect("t2", 7, 16'b1110001, 16'b0000010, 16'b1111111);

        // Test 3: odd divisor, then a transfer landing on a terminal cycle.
        do_reset();
        program_div(28'd5);
        check_val("t3 div5", 32'(active_div), 32'd5);
        enable = 1'b1;
        step();
        run_expect("t3", 9, 16'b110001100, 16'b000010000, 16'b111111111);
        cfg_div   = 28'd3;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        cfg_div   = 28'd1;
        check_val("t3 term tick", 32'(tick), 32'd1);
        check_val("t3 term clk", 32'(clock_out), 32'd0);
        check_val("t3 term div", 32'(active_div), 32'd3);
        check_val("t3 term ready", 32'(cfg_ready), 32'd1);
        run_expect("t3b", 4, 16'b1001, 16'b0010, 16'b1111);

        // Test 4: stop at the period boundary, then stop cancelled mid-period.
        do_reset();
        program_div(28'd6);
        enable = 1'b1;
        step();
        step();
        check_val("t4a e1 clk", 32'(clock_out), 32'd1);
        enable = 1'b0;
        run_expect("t4a", 7, 16'b1100000, 16'b0000100, 16'b1111000);
        enable = 1'b1;
        step();
        step();
        check_val("t4b e1 clk", 32'(clock_out), 32'd1);
        enable = 1'b0;
        run_expect("t4b1", 2, 16'b11, 16'b00, 16'b11);
        enable = 1'b1;
        run_expect("t4b2", 7, 16'b0001110, 16'b0010000, 16'b1111111);
        step();
        check_val("t4c e11 clk", 32'(clock_out), 32'd0);
        enable = 1'b0;
        step();
        check_val("t4c stop busy", 32'(busy), 32'd0);
        check_val("t4c stop tick", 32'(tick), 32'd1);

        // Test 5: illegal divisor.
        do_reset();
        program_div(28'd5);
        cfg_div   = 28'd1;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
`ifdef DIV_ERR_EN
        check_val("t5 err pulse", 32'(cfg_err), 32'd1);
        check_val("t5 div kept", 32'(active_div), 32'd5);
        step();
        check_val("t5 err clear", 32'(cfg_err), 32'd0);
        check_val("t5 div kept2", 32'(active_div), 32'd5);
        check_val("t5 ready", 32'(cfg_ready), 32'd1);
`else
        check_val("t5 clamp1", 32'(active_div), 32'd2);
        check_val("t5 ready", 32'(cfg_ready), 32'd1);
        program_div(28'd7);
        program_div(28'd0);
        check_val("t5 clamp0", 32'(active_div), 32'd2);
`endif

        // Test 6: reset mid-period discards a parked divisor.
        do_reset();
        program_div(28'd8);
        enable = 1'b1;
        step();
        step();
        cfg_div   = 28'd3;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check_val("t6 ready low", 32'(cfg_ready), 32'd0);
        step();
        check_val("t6 e3 clk", 32'(clock_out), 32'd1);
        step();
        step();
        check_val("t6 e5 clk", 32'(clock_out), 32'd0);
        check_val("t6 e5 div", 32'(active_div), 32'd8);
        reset = 1'b1;
        step();
        check_val("t6 rst clk", 32'(clock_out), 32'd0);
        check_val("t6 rst tick", 32'(tick), 32'd0);
        check_val("t6 rst busy", 32'(busy), 32'd0);
        check_val("t6 rst div", 32'(active_div), 32'd2);
        check_val("t6 rst ready", 32'(cfg_ready), 32'd1);
        reset  = 1'b0;
        enable = 1'b0;
        repeat (10) step();
        check_val("t6 post div", 32'(active_div), 32'd2);
        check_val("t6 post busy", 32'(busy), 32'd0);
        check_val("t6 post ready", 32'(cfg_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
